// File: rtl/spi_adc_reader.sv
// SPI reader for the 16-bit serial ADC: free-running SCLK, CS framing, MSB-first capture
// and extraction of the 8-bit sample carried in word[12:5].
module spi_adc_reader #(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned CS_HIGH_SCLKS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        SDO,
  output logic        SCLK,
  output logic        CS,
  output logic        busy,
  output logic [7:0]  data,
  output logic [15:0] word,
  output logic        data_valid,
  output logic        frame_err
);

  localparam int unsigned DivW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GapW = (CS_HIGH_SCLKS > 1) ? $clog2(CS_HIGH_SCLKS) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(CS_HIGH_SCLKS - 1);

  typedef enum logic [1:0] {StIdle, StArm, StShift, StGap} state_e;

  logic [DivW-1:0] div_cnt;
  logic            tick;
  logic            rise_evt;
  logic            fall_evt;

  state_e          state;
  logic [3:0]      bit_cnt;
  logic [15:0]     shift;
  logic [GapW-1:0] gap_cnt;
  logic [15:0]     next_word;

  assign tick      = (div_cnt == DivLast);
  assign rise_evt  = tick & ~SCLK;
  assign fall_evt  = tick & SCLK;
  assign next_word = {shift[14:0], SDO};

  // SCLK free-runs in every state so the peripheral always sees reload edges while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      SCLK    <= 1'b1;
    end else if (tick) begin
      div_cnt <= '0;
      SCLK    <= ~SCLK;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      CS         <= 1'b1;
      busy       <= 1'b0;
      bit_cnt    <= '0;
      shift      <= '0;
      gap_cnt    <= '0;
      word       <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            state <= StArm;
            busy  <= 1'b1;
          end
        end
        StArm: begin
          // CS drops on a rise so the first sampling rise is a full SCLK period later.
          if (rise_evt) begin
            CS      <= 1'b0;
            bit_cnt <= '0;
            state   <= StShift;
          end
        end
        StShift: begin
          if (rise_evt) begin
            shift   <= next_word;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) begin
              CS         <= 1'b1;
              word       <= next_word;
              data       <= next_word[12:5];
              frame_err  <= (|next_word[15:13]) | (|next_word[4:0]);
              data_valid <= 1'b1;
              gap_cnt    <= '0;
              state      <= StGap;
            end
          end
        end
        StGap: begin
          if (fall_evt) begin
            if (gap_cnt == GapLast) begin
              state <= StIdle;
              busy  <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
          CS    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_adc_reader.sv
// Directed bench for spi_adc_reader: two instances (CLK_DIV=4/GAP=1 and CLK_DIV=2/GAP=3),
// each driven by a small peripheral model that shifts a word out on SCLK falling edges.
module tb_spi_adc_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic        force_ones = 1'b0;
  logic        sdo;
  logic        sdo_model = 1'b0;
  logic        sdo2 = 1'b0;

  logic        sclk, cs, busy, dv, ferr;
  logic [7:0]  data;
  logic [15:0] word;
  logic        sclk2, cs2, busy2, dv2, ferr2;
  logic [7:0]  data2;
  logic [15:0] word2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_adc_reader #(.CLK_DIV(4), .CS_HIGH_SCLKS(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .SDO        (sdo),
    .SCLK       (sclk),
    .CS         (cs),
    .busy       (busy),
    .data       (data),
    .word       (word),
    .data_valid (dv),
    .frame_err  (ferr)
  );

  spi_adc_reader #(.CLK_DIV(2), .CS_HIGH_SCLKS(3)) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start2),
    .SDO        (sdo2),
    .SCLK       (sclk2),
    .CS         (cs2),
    .busy       (busy2),
    .data       (data2),
    .word       (word2),
    .data_valid (dv2),
    .frame_err  (ferr2)
  );

  // Peripheral model for dut: one word per CS-low window, bit15 on the first fall after CS drops.
  logic [15:0] words [0:15];
  logic [15:0] cur_word = '0;
  int widx = 0;
  int bit_idx = 15;
  int fall_cnt = 0;
  int fc_cs_rise = 0;
  int fc_cs_fall = 0;
  int gap_falls = 0;
  int low_falls = 0;

  assign sdo = force_ones ? 1'b1 : sdo_model;

  always @(negedge cs) begin
    cur_word   = words[widx];
    widx       = widx + 1;
    gap_falls  = fall_cnt - fc_cs_rise;
    fc_cs_fall = fall_cnt;
  end

  always @(posedge cs) begin
    fc_cs_rise = fall_cnt;
    low_falls  = fall_cnt - fc_cs_fall;
  end

  always @(negedge sclk) begin
    fall_cnt = fall_cnt + 1;
    if (!cs) begin
      if (bit_idx >= 0) sdo_model = cur_word[bit_idx];
      bit_idx = bit_idx - 1;
    end else begin
      bit_idx = 15;
    end
  end

  logic [15:0] word2_src = 16'h14A0;
  int bit_idx2 = 15;

  always @(negedge sclk2) begin
    if (!cs2) begin
      if (bit_idx2 >= 0) sdo2 = word2_src[bit_idx2];
      bit_idx2 = bit_idx2 - 1;
    end else begin
      bit_idx2 = 15;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (dv) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_cs_low(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!cs) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt_dv;
    int cnt_cs;
    int falls;
    int t_first;
    int period;
    bit ok;
    bit prev;
    logic [7:0] exp_data [0:2];

    words[0] = 16'h1FE0;
    words[1] = 16'h0A40;
    words[2] = 16'h14A0;
    words[3] = 16'h0780;
    words[4] = 16'h0000;
    words[5] = 16'h0A40;
    words[6] = 16'h14A0;
    words[7] = 16'h0780;
    words[8] = 16'h0C20;
    for (int i = 9; i < 16; i++) words[i] = 16'h0000;
    exp_data[0] = 8'h52;
    exp_data[1] = 8'hA5;
    exp_data[2] = 8'h3C;

    // Reset values appear before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("rst_sclk", sclk, 1);
    check("rst_cs", cs, 1);
    check("rst_busy", busy, 0);
    check("rst_data", data, 0);
    check("rst_word", word, 0);
    check("rst_valid", dv, 0);
    check("rst_ferr", ferr, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single frame, word 1FE0.
    pulse_start();
    check("busy_after_start", busy, 1);
    wait_valid(300, n);
    check("t1_latency_ok", (n >= 129) && (n <= 136), 1);
    check("t1_word", word, 16'h1FE0);
    check("t1_data", data, 8'hFF);
    check("t1_ferr", ferr, 0);
    check("t1_cs_low_falls", low_falls, 16);
    @(negedge clk);
    check("t1_valid_one_cycle", dv, 0);
    wait_idle(50, ok);
    check("t1_idle", ok, 1);

    // Back-to-back frames with start held.
    start = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_valid(400, n);
      check("t2_valid_seen", n > 0, 1);
      check("t2_data", data, exp_data[f]);
      check("t2_ferr", ferr, 0);
      if (f > 0) check("t2_gap_falls", gap_falls, 1);
    end
    start = 1'b0;
    wait_idle(50, ok);
    check("t2_idle", ok, 1);
    check("t2_cs_high", cs, 1);

    // Stuck-high SDO, then a good frame clears frame_err.
    force_ones = 1'b1;
    pulse_start();
    wait_valid(300, n);
    force_ones = 1'b0;
    check("t3_valid_seen", n > 0, 1);
    check("t3_word", word, 16'hFFFF);
    check("t3_data", data, 8'hFF);
    check("t3_ferr", ferr, 1);
    wait_idle(50, ok);
    pulse_start();
    wait_valid(300, n);
    check("t3b_word", word, 16'h0A40);
    check("t3b_data", data, 8'h52);
    check("t3b_ferr", ferr, 0);
    wait_idle(50, ok);

    // start while busy in SHIFT and in GAP is ignored.
    pulse_start();
    wait_cs_low(50, ok);
    check("t4_cs_low", ok, 1);
    repeat (20) @(negedge clk);
    pulse_start();
    wait_valid(300, n);
    check("t4_valid_seen", n > 0, 1);
    check("t4_word", word, 16'h14A0);
    check("t4_busy_in_gap", busy, 1);
    pulse_start();
    wait_idle(50, ok);
    check("t4_idle", ok, 1);
    cnt_dv = 0;
    cnt_cs = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dv) cnt_dv++;
      if (!cs) cnt_cs++;
    end
    check("t4_extra_valid", cnt_dv, 0);
    check("t4_extra_cs_low", cnt_cs, 0);
    check("t4_word_held", word, 16'h14A0);

    // Asynchronous reset around bit 8.
    pulse_start();
    wait_cs_low(50, ok);
    repeat (68) @(negedge clk);
    check("t5_mid_frame", cs, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_cs", cs, 1);
    check("t5_sclk", sclk, 1);
    check("t5_busy", busy, 0);
    check("t5_valid", dv, 0);
    check("t5_data", data, 0);
    check("t5_word", word, 0);
    cnt_dv = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (dv) cnt_dv++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dv) cnt_dv++;
    end
    check("t5_no_valid", cnt_dv, 0);
    pulse_start();
    wait_valid(300, n);
    check("t5b_word", word, 16'h0C20);
    check("t5b_data", data, 8'h61);
    check("t5b_ferr", ferr, 0);

    // CLK_DIV=2, CS_HIGH_SCLKS=3 instance.
    t_first = -1;
    period = -1;
    prev = sclk2;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!prev && sclk2) begin
        if (t_first < 0) t_first = i;
        else if (period < 0) period = i - t_first;
      end
      prev = sclk2;
    end
    check("t6_sclk_period", period, 4);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (dv2) begin
        n = i;
        break;
      end
    end
    check("t6_valid_seen", n > 0, 1);
    check("t6_word", word2, 16'h14A0);
    check("t6_data", data2, 8'hA5);
    check("t6_ferr", ferr2, 0);
    falls = 0;
    prev = sclk2;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (prev && !sclk2) falls++;
      prev = sclk2;
      if (!busy2) break;
    end
    check("t6_gap_falls", falls, 3);
    check("t6_busy", busy2, 0);
    check("t6_cs", cs2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_adc_reader.md
Name: spi_adc_reader

Overview:
- Synthesizable SPI controller (reader) for our 16-bit serial ADC peripheral.
- Generates a free-running SCLK and frames CS.
- Samples SDO MSB-first and extracts the 8-bit sample carried in bits [12:5].
- Checks that the zero-padding bits are zero and hands the result to downstream logic with a one-cycle valid pulse.

Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period (legal values ≥2); SCLK period = 2*CLK_DIV clk cycles.
- CS_HIGH_SCLKS, 1, minimum SCLK falling edges with CS high between frames (legal values ≥1; the peripheral reloads on a falling edge while CS is high).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request one conversion frame; sampled only in IDLE.
- SDO  input  1  serial data from the peripheral; changes on SCLK falling edge.
- SCLK  output  1  serial clock, registered.
- CS  output  1  chip select, active low, registered.
- busy  output  1  high from ARM through the end of GAP.
- data  output  8  last extracted sample, word[12:5].
- word  output  16  last raw received word.
- data_valid  output  1  one-cycle pulse when data/word/frame_err update.
- frame_err  output  1  set with data_valid if word[15:13] != 0 or word[4:0] != 0.

Behaviour:
- Reset (rst_n=0, async) drives these values immediately:
  - SCLK=1, CS=1, busy=0, data=0, word=0, data_valid=0, frame_err=0.
  - Divider counter=0, state=IDLE.
  - Reset mid-frame aborts the frame with no data_valid.
- Divider:
  - Counter runs 0..CLK_DIV-1 continuously out of reset.
  - At CLK_DIV-1, SCLK toggles and the counter returns to 0.
  - Rise event = the cycle SCLK goes 0→1; fall event = the cycle SCLK goes 1→0.
  - SCLK runs in all states.
- FSM states:
  - IDLE: CS=1, busy=0. start=1 → ARM.
  - ARM: CS=1, busy=1. At the next rise event: CS←0, bit counter←0, → SHIFT.
  - SHIFT: CS=0.
    - At each rise event, SDO is shifted into the LSB of the shift register and the bit counter increments.
    - The first rise after CS falls samples bit15. The 16th rise samples bit0.
    - On the 16th rise, in the same cycle: CS←1, word←shift result, → GAP.
  - GAP: CS=1, busy=1. Count fall events; after CS_HIGH_SCLKS of them → IDLE.
- Output update:
  - data_valid pulses in the cycle after the 16th rise event.
  - data, word and frame_err update in that same cycle and hold until the next frame completes.
- Latency (start in IDLE → data_valid):
  - Minimum 1 + 32*CLK_DIV + 1 clk cycles.
  - Maximum adds up to 2*CLK_DIV - 1 cycles of ARM wait.
- Boundary conditions:
  - start while busy (ARM/SHIFT/GAP) is ignored; there is no queueing.
  - start held high in IDLE starts back-to-back frames, separated only by the GAP.
  - SDO is ignored outside SHIFT.
  - frame_err is recomputed every frame; it is not sticky.

Test Plan:
- Reset, then a single start with CLK_DIV=4:
  - Observe 16 SCLK falling edges with CS low.
  - Required: word=16'h1FE0, data=8'hFF, frame_err=0, data_valid high for exactly one cycle, 1+128+1 to 1+128+8 cycles after start.
- start held high for three frames against the peripheral model:
  - Each frame's data equals the model's printed word[12:5].
  - CS high for ≥1 SCLK falling edge between frames.
  - frame_err=0 throughout.
- Forced SDO=1 for the whole frame:
  - Required: word=16'hFFFF, data=8'hFF, frame_err=1.
  - Next good frame clears frame_err to 0.
- start pulsed again during SHIFT and again during GAP:
  - Required: no additional frame, a single data_valid, busy falls after GAP.
- rst_n asserted at bit 8 of a frame:
  - Required: CS=1 and SCLK=1 immediately (asynchronous), busy=0, no data_valid, data/word=0.
  - Next start produces a correct frame.
- CLK_DIV=2, CS_HIGH_SCLKS=3:
  - Required: SCLK period 4 clk cycles, exactly 3 fall events with CS high before IDLE.
  - Data still correct.
